// File: rtl/tdc_pkg.sv
// Shared types and helpers for the hsc TDC readout path.
// Provides the readout FSM state type, default line length and the hw clamp.
package tdc_pkg;

    localparam int unsigned TDC_N    = 64;
    localparam int unsigned TDC_HW_W = $clog2(TDC_N) + 1;

    typedef enum logic [1:0] {RO_IDLE, RO_ACCUM, RO_HOLD} ro_state_t;

    // Codes above the tap count are physically impossible and are saturated to n.
    function automatic int unsigned clamp_hw(input int unsigned hw, input int unsigned n);
        return (hw > n) ? n : hw;
    endfunction

endpackage

// File: rtl/tdc_readout_acc.sv
// Window datapath for tdc_readout: clamp, running sum, sample counter and,
// when TDC_READOUT_MINMAX_EN is defined, running min/max of clamped samples.
module tdc_readout_acc
    import tdc_pkg::*;
#(
    parameter int unsigned N        = TDC_N,
    parameter int unsigned HW_W     = TDC_HW_W,
    parameter int unsigned LOG2_AVG = 4,
    parameter int unsigned ACC_W    = HW_W + LOG2_AVG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add,
    input  logic [HW_W-1:0]  hw_in,
    output logic             over,
    output logic             last,
    output logic [ACC_W-1:0] sum_next
`ifdef TDC_READOUT_MINMAX_EN
    ,
    output logic [HW_W-1:0]  min_next,
    output logic [HW_W-1:0]  max_next
`endif
);

    logic [HW_W-1:0]     hw_c;
    logic [ACC_W-1:0]    acc_q;
    logic [LOG2_AVG-1:0] cnt_q;

    assign hw_c     = HW_W'(clamp_hw(32'(hw_in), N));
    assign over     = 32'(hw_in) > N;
    assign last     = &cnt_q;
    assign sum_next = acc_q + ACC_W'(hw_c);

    // cnt wraps to 0 on the final sample, so no explicit clear is needed there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (add) begin
            acc_q <= sum_next;
            cnt_q <= cnt_q + LOG2_AVG'(1);
        end
    end

`ifdef TDC_READOUT_MINMAX_EN
    logic [HW_W-1:0] min_q;
    logic [HW_W-1:0] max_q;

    assign min_next = (hw_c < min_q) ? hw_c : min_q;
    assign max_next = (hw_c > max_q) ? hw_c : max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= HW_W'(N);
            max_q <= '0;
        end else if (clr) begin
            min_q <= HW_W'(N);
            max_q <= '0;
        end else if (add) begin
            min_q <= min_next;
            max_q <= max_next;
        end
    end
`endif

endmodule

// File: rtl/tdc_readout.sv
// Readout engine for the hsc TDC: averages 2^LOG2_AVG hw codes and hands off via valid/ready.
// Optional min/max outputs are enabled by defining TDC_READOUT_MINMAX_EN.
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int unsigned N        = TDC_N,
    parameter int unsigned HW_W     = $clog2(N) + 1,
    parameter int unsigned LOG2_AVG = 4,
    parameter int unsigned ACC_W    = HW_W + LOG2_AVG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cont,
    input  logic [HW_W-1:0]  hw_in,
    input  logic             hw_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [HW_W-1:0]  out_mean,
`ifdef TDC_READOUT_MINMAX_EN
    output logic [HW_W-1:0]  out_min,
    output logic [HW_W-1:0]  out_max,
`endif
    output logic             busy,
    output logic             overrun,
    output logic             clamped
);

    ro_state_t        state;
    logic             clr;
    logic             add;
    logic             over;
    logic             last;
    logic [ACC_W-1:0] sum_next;
`ifdef TDC_READOUT_MINMAX_EN
    logic [HW_W-1:0]  min_next;
    logic [HW_W-1:0]  max_next;
`endif

    // start beats hw_valid in ACCUM; HOLD re-arms only through the handshake.
    always_comb begin
        clr = 1'b0;
        add = 1'b0;
        if (ena) begin
            case (state)
                RO_IDLE:  clr = start;
                RO_ACCUM: begin
                    clr = start;
                    add = hw_valid & ~start;
                end
                RO_HOLD:  clr = out_ready & cont;
                default:  ;
            endcase
        end
    end

    tdc_readout_acc #(
        .N        (N),
        .HW_W     (HW_W),
        .LOG2_AVG (LOG2_AVG),
        .ACC_W    (ACC_W)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .add      (add),
        .hw_in    (hw_in),
        .over     (over),
        .last     (last),
`ifdef TDC_READOUT_MINMAX_EN
        .min_next (min_next),
        .max_next (max_next),
`endif
        .sum_next (sum_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RO_IDLE;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_mean  <= '0;
            overrun   <= 1'b0;
            clamped   <= 1'b0;
`ifdef TDC_READOUT_MINMAX_EN
            out_min   <= '0;
            out_max   <= '0;
`endif
        end else if (ena) begin
            case (state)
                RO_IDLE: begin
                    if (start) begin
                        state   <= RO_ACCUM;
                        overrun <= 1'b0;
                        clamped <= 1'b0;
                    end
                end
                RO_ACCUM: begin
                    if (add) begin
                        if (over) clamped <= 1'b1;
                        if (last) begin
                            out_sum   <= sum_next;
                            out_mean  <= sum_next[ACC_W-1:LOG2_AVG];
`ifdef TDC_READOUT_MINMAX_EN
                            out_min   <= min_next;
                            out_max   <= max_next;
`endif
                            out_valid <= 1'b1;
                            state     <= RO_HOLD;
                        end
                    end
                end
                RO_HOLD: begin
                    // A sample coinciding with a continuous re-arm is not an overrun.
                    if (hw_valid && !(out_ready && cont)) overrun <= 1'b1;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= cont ? RO_ACCUM : RO_IDLE;
                    end
                end
                default: state <= RO_IDLE;
            endcase
        end
    end

    assign busy = (state == RO_ACCUM);

endmodule
